button_seq_lock: RTL and testbench

BUTTON_SEQ_LOCK -- requirements
Module: button_seq_lock

---
 rtl/button_lock_pkg.sv | 27 ++
 rtl/btn_press_det.sv | 38 +++
 rtl/button_seq_lock.sv | 167 ++++++++++++++++
 tb/tb_button_seq_lock.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/button_lock_pkg.sv
// Shared state encoding and default configuration for the button sequence lock.
`timescale 1ns/1ps
package button_lock_pkg;

  localparam int DEF_N_BUTTONS      = 3;
  localparam int DEF_SEQ_LEN        = 4;
  localparam logic [11:0] DEF_CODE  = 12'hCA9;
  localparam int DEF_HOLD_CYCLES    = 20;
  localparam int DEF_TIMEOUT_CYCLES = 50;
  localparam int DEF_MAX_FAIL       = 3;
  localparam int DEF_LOCKOUT_CYCLES = 40;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ENTRY   = 3'd1,
    OPEN    = 3'd2,
    PROGRAM = 3'd3,
    LOCKOUT = 3'd4
  } lock_state_e;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/btn_press_det.sv
// Two-flop button synchronizer with registered press-event detection.
`timescale 1ns/1ps
module btn_press_det #(
  parameter int N_BUTTONS = 3
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn,
  output logic                 press,
  output logic [N_BUTTONS-1:0] press_val
);

  logic [N_BUTTONS-1:0] sync1;
  logic [N_BUTTONS-1:0] sync2;
  logic [1:0]           fill;
  logic                 armed;

  // armed only once sync2 holds a genuine all-zero sample of btn, so a button
  // held through reset release never produces an event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1     <= '0;
      sync2     <= '0;
      fill      <= '0;
      armed     <= 1'b0;
      press     <= 1'b0;
      press_val <= '0;
    end else begin
      sync1     <= btn;
      sync2     <= sync1;
      fill      <= {fill[0], 1'b1};
      armed     <= fill[1] && (sync2 == '0);
      press     <= armed && (sync2 != '0);
      press_val <= sync2;
    end
  end

endmodule

// File: rtl/button_seq_lock.sv
// Sequence-code lock: N-event button code entry, timed unlock, reprogramming and lockout.
`timescale 1ns/1ps
module button_seq_lock
  import button_lock_pkg::*;
#(
  parameter int N_BUTTONS      = DEF_N_BUTTONS,
  parameter int SEQ_LEN        = DEF_SEQ_LEN,
  parameter logic [N_BUTTONS*SEQ_LEN-1:0] DEFAULT_CODE = DEF_CODE,
  parameter int HOLD_CYCLES    = DEF_HOLD_CYCLES,
  parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
  parameter int MAX_FAIL       = DEF_MAX_FAIL,
  parameter int LOCKOUT_CYCLES = DEF_LOCKOUT_CYCLES
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [N_BUTTONS-1:0] btn,
  input  logic                 prog_en,
  output logic                 signal,
  output logic                 lockout,
  output logic                 busy
);

  localparam int CODE_W = N_BUTTONS * SEQ_LEN;
  localparam int TMR_W  = $clog2(max3(HOLD_CYCLES, TIMEOUT_CYCLES, LOCKOUT_CYCLES));
  localparam int IDX_W  = $clog2(SEQ_LEN);
  localparam int FAIL_W = $clog2(MAX_FAIL + 1);

  localparam logic [TMR_W-1:0]  TMR_MAX      = '1;
  localparam logic [TMR_W-1:0]  HOLD_LAST    = TMR_W'(HOLD_CYCLES - 1);
  localparam logic [TMR_W-1:0]  TIMEOUT_LAST = TMR_W'(TIMEOUT_CYCLES - 1);
  localparam logic [TMR_W-1:0]  LOCK_LAST    = TMR_W'(LOCKOUT_CYCLES - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST     = IDX_W'(SEQ_LEN - 1);
  localparam logic [FAIL_W-1:0] FAIL_LAST    = FAIL_W'(MAX_FAIL - 1);
  localparam logic [FAIL_W-1:0] FAIL_MAX     = FAIL_W'(MAX_FAIL);

  lock_state_e state, state_nxt;

  logic                 press;
  logic [N_BUTTONS-1:0] press_val;
  logic [TMR_W-1:0]     timer;
  logic [IDX_W-1:0]     index;
  logic                 mismatch;
  logic [FAIL_W-1:0]    fail_cnt;
  logic [CODE_W-1:0]    code;
  logic [CODE_W-1:0]    new_code;
  logic [CODE_W-1:0]    prog_word;
  logic                 step_mis;
  logic                 fail_inc;
  logic                 fail_clr;
  logic                 commit;

  btn_press_det #(.N_BUTTONS(N_BUTTONS)) u_press_det (
    .clk       (clk),
    .reset     (reset),
    .btn       (btn),
    .press     (press),
    .press_val (press_val)
  );

  function automatic logic [N_BUTTONS-1:0] code_entry(input logic [CODE_W-1:0] c,
                                                      input logic [IDX_W-1:0]  i);
    return c[int'(i)*N_BUTTONS +: N_BUTTONS];
  endfunction

  assign step_mis = (press_val != code_entry(code, index));

  // shadow code with the current event merged in at the current index
  always_comb begin
    prog_word = new_code;
    prog_word[int'(index)*N_BUTTONS +: N_BUTTONS] = press_val;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    fail_inc  = 1'b0;
    fail_clr  = 1'b0;
    commit    = 1'b0;
    case (state)
      IDLE: begin
        if (press) state_nxt = ENTRY;
      end
      ENTRY: begin
        if (press) begin
          if (index == IDX_LAST) begin
            if (!(mismatch || step_mis)) begin
              state_nxt = OPEN;
              fail_clr  = 1'b1;
            end else begin
              fail_inc  = 1'b1;
              state_nxt = (fail_cnt >= FAIL_LAST) ? LOCKOUT : IDLE;
            end
          end
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt = IDLE;
        end
      end
      OPEN: begin
        if (press && prog_en)        state_nxt = PROGRAM;
        else if (timer == HOLD_LAST) state_nxt = IDLE;
      end
      PROGRAM: begin
        if (press) begin
          if (index == IDX_LAST) begin
            state_nxt = IDLE;
            commit    = 1'b1;
          end
        end else if (timer == TIMEOUT_LAST) begin
          state_nxt = IDLE;
        end
      end
      LOCKOUT: begin
        if (timer == LOCK_LAST) begin
          state_nxt = IDLE;
          fail_clr  = 1'b1;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // timer restarts on every state change and on every accepted entry/program event
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      timer    <= '0;
      index    <= '0;
      mismatch <= 1'b0;
      fail_cnt <= '0;
      new_code <= DEFAULT_CODE;
      code     <= DEFAULT_CODE;
    end else begin
      if ((state_nxt != state) || (press && busy))
        timer <= '0;
      else if (timer != TMR_MAX)
        timer <= timer + TMR_W'(1);

      if (state_nxt != state)
        index <= ((state_nxt == ENTRY) || (state_nxt == PROGRAM)) ? IDX_W'(1) : '0;
      else if (press && busy && (index != IDX_LAST))
        index <= index + IDX_W'(1);

      if (press && (state == IDLE))
        mismatch <= step_mis;
      else if (press && (state == ENTRY))
        mismatch <= mismatch | step_mis;

      if (fail_clr)
        fail_cnt <= '0;
      else if (fail_inc && (fail_cnt != FAIL_MAX))
        fail_cnt <= fail_cnt + FAIL_W'(1);

      if (press && (((state == OPEN) && prog_en) || (state == PROGRAM)))
        new_code <= prog_word;
      if (commit)
        code <= prog_word;
    end
  end

  assign signal  = (state == OPEN);
  assign lockout = (state == LOCKOUT);
  assign busy    = (state == ENTRY) || (state == PROGRAM);

endmodule

// File: tb/tb_button_seq_lock.sv
// Directed bench for button_seq_lock: entry, failures, lockout, timeout, programming, reset.
`timescale 1ns/1ps
module tb_button_seq_lock;

  localparam logic [11:0] GOOD = 12'hCA9;  // 001,101,010,110
  localparam logic [11:0] BAD  = 12'hCE9;  // 001,101,011,110
  localparam logic [11:0] NEWC = 12'h2E4;  // 100,100,011,001

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [2:0] btn = 3'b000;
  logic       prog_en = 1'b0;
  logic       signal, lockout, busy;

  int checks = 0;
  int failures = 0;
  int sig_cycles = 0;
  int lock_cycles = 0;
  int s0, l0;

  button_seq_lock dut (
    .clk     (clk),
    .reset   (reset),
    .btn     (btn),
    .prog_en (prog_en),
    .signal  (signal),
    .lockout (lockout),
    .busy    (busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (signal)  sig_cycles  <= sig_cycles + 1;
    if (lockout) lock_cycles <= lock_cycles + 1;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp)
    else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic do_press(input logic [2:0] v);
    @(negedge clk) btn = v;
    repeat (3) @(negedge clk);
    btn = 3'b000;
    repeat (3) @(negedge clk);
  endtask

  task automatic enter_code(input logic [11:0] c);
    logic [2:0] v;
    for (int i = 0; i < 4; i++) begin
      v = c[i*3 +: 3];
      do_press(v);
    end
  endtask

  initial begin
    // reset state, with a button held through reset release
    btn = 3'b001;
    repeat (3) @(negedge clk);
    chk("rst_signal", {31'd0, signal}, 32'd0);
    chk("rst_lockout", {31'd0, lockout}, 32'd0);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_fail_cnt", 32'(dut.fail_cnt), 32'd0);
    chk("rst_code", 32'(dut.code), 32'(GOOD));
    reset = 1'b1;
    repeat (10) @(negedge clk);
    chk("held_btn_no_event", {31'd0, busy}, 32'd0);
    btn = 3'b000;
    repeat (5) @(negedge clk);

    // correct code with latency and hold length
    s0 = sig_cycles;
    do_press(3'b001);
    chk("entry_busy", {31'd0, busy}, 32'd1);
    do_press(3'b101);
    do_press(3'b010);
    @(negedge clk) btn = 3'b110;
    repeat (3) @(posedge clk);
    #1 chk("latency_edge2", {31'd0, signal}, 32'd0);
    @(posedge clk);
    #1 chk("latency_edge3", {31'd0, signal}, 32'd1);
    chk("open_not_lockout", {31'd0, lockout}, 32'd0);
    @(negedge clk) btn = 3'b000;
    repeat (25) @(negedge clk);
    chk("hold_cycles", 32'(sig_cycles - s0), 32'd20);
    chk("open_fail_cnt", 32'(dut.fail_cnt), 32'd0);

    // one wrong code
    s0 = sig_cycles;
    do_press(3'b001);
    do_press(3'b101);
    do_press(3'b011);
    chk("wrong_busy_before_last", {31'd0, busy}, 32'd1);
    do_press(3'b110);
    chk("wrong_busy_after_last", {31'd0, busy}, 32'd0);
    chk("wrong_no_signal", 32'(sig_cycles - s0), 32'd0);
    chk("wrong_fail_cnt", 32'(dut.fail_cnt), 32'd1);

    // two more wrong codes reach lockout
    enter_code(BAD);
    chk("fail_cnt_2", 32'(dut.fail_cnt), 32'd2);
    chk("no_lockout_yet", {31'd0, lockout}, 32'd0);
    l0 = lock_cycles;
    enter_code(BAD);
    chk("lockout_entered", {31'd0, lockout}, 32'd1);
    chk("lockout_fail_cnt", 32'(dut.fail_cnt), 32'd3);
    s0 = sig_cycles;
    enter_code(GOOD);
    chk("lockout_still_high", {31'd0, lockout}, 32'd1);
    repeat (30) @(negedge clk);
    chk("lockout_ignored_code", 32'(sig_cycles - s0), 32'd0);
    chk("lockout_done", {31'd0, lockout}, 32'd0);
    chk("lockout_length", 32'(lock_cycles - l0), 32'd40);
    chk("lockout_clears_fail", 32'(dut.fail_cnt), 32'd0);
    chk("lockout_no_entry", {31'd0, busy}, 32'd0);
    s0 = sig_cycles;
    enter_code(GOOD);
    repeat (25) @(negedge clk);
    chk("after_lockout_opens", 32'(sig_cycles - s0), 32'd20);

    // entry timeout
    do_press(3'b001);
    do_press(3'b101);
    repeat (40) @(negedge clk);
    chk("timeout_still_busy", {31'd0, busy}, 32'd1);
    repeat (10) @(negedge clk);
    chk("timeout_idle", {31'd0, busy}, 32'd0);
    chk("timeout_fail_cnt", 32'(dut.fail_cnt), 32'd0);
    s0 = sig_cycles;
    enter_code(GOOD);
    repeat (25) @(negedge clk);
    chk("after_timeout_opens", 32'(sig_cycles - s0), 32'd20);

    // reprogramming
    enter_code(GOOD);
    chk("open_before_prog", {31'd0, signal}, 32'd1);
    prog_en = 1'b1;
    do_press(3'b100);
    chk("prog_busy", {31'd0, busy}, 32'd1);
    chk("prog_signal_low", {31'd0, signal}, 32'd0);
    do_press(3'b100);
    do_press(3'b011);
    chk("prog_code_unchanged", 32'(dut.code), 32'(GOOD));
    do_press(3'b001);
    prog_en = 1'b0;
    chk("prog_done_idle", {31'd0, busy}, 32'd0);
    chk("prog_new_code", 32'(dut.code), 32'(NEWC));
    s0 = sig_cycles;
    enter_code(NEWC);
    repeat (25) @(negedge clk);
    chk("new_code_opens", 32'(sig_cycles - s0), 32'd20);
    s0 = sig_cycles;
    enter_code(GOOD);
    repeat (5) @(negedge clk);
    chk("old_code_fails", 32'(sig_cycles - s0), 32'd0);
    chk("old_code_fail_cnt", 32'(dut.fail_cnt), 32'd1);

    // reset in the middle of programming
    enter_code(NEWC);
    prog_en = 1'b1;
    do_press(3'b010);
    do_press(3'b111);
    chk("mid_prog_busy", {31'd0, busy}, 32'd1);
    @(negedge clk);
    #2 reset = 1'b0;
    #1 chk("mid_prog_rst_busy", {31'd0, busy}, 32'd0);
    chk("mid_prog_rst_code", 32'(dut.code), 32'(GOOD));
    chk("mid_prog_rst_fail", 32'(dut.fail_cnt), 32'd0);
    @(negedge clk) reset = 1'b1;
    prog_en = 1'b0;
    repeat (3) @(negedge clk);

    // asynchronous reset while open
    enter_code(GOOD);
    chk("default_restored_opens", {31'd0, signal}, 32'd1);
    #2 reset = 1'b0;
    #1 chk("async_rst_signal", {31'd0, signal}, 32'd0);
    chk("async_rst_lockout", {31'd0, lockout}, 32'd0);
    @(negedge clk) reset = 1'b1;
    repeat (5) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
